// File: rtl/btb_pkg.sv
// Shared definitions for the BTB update path: update kinds, default widths,
// classification outcomes and the {kind, pc, bta} update-entry layout.
package btb_pkg;

  localparam logic [1:0] UPD_INSERT     = 2'b01;
  localparam logic [1:0] UPD_INVALIDATE = 2'b10;

  localparam int W_PC_DEFAULT  = 8;
  localparam int W_BTA_DEFAULT = 32;
  localparam int W_KIND        = 2;

  // Outcome of comparing a resolved branch against its fetch-time prediction
  typedef enum logic [1:0] {
    CLS_CORRECT    = 2'd0,
    CLS_INSERT     = 2'd1,
    CLS_INVALIDATE = 2'd2
  } cls_e;

  // Update entry is packed MSB-first as {kind, pc, bta}
  function automatic int upd_entry_w(input int w_pc, input int w_bta);
    return W_KIND + w_pc + w_bta;
  endfunction

endpackage

// File: rtl/btb_upd_fifo.sv
// Pending-update FIFO for the BTB write port. Power-of-two depth, pointers
// wrap naturally. ovr_i rewrites the newest (tail) entry in place instead of
// allocating, which is what update coalescing uses.
module btb_upd_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     rst_ni,
  input  logic                     push_i,
  input  logic                     pop_i,
  input  logic                     ovr_i,
  input  logic [WIDTH-1:0]         wdata_i,
  output logic [WIDTH-1:0]         head_o,
  output logic [WIDTH-1:0]         tail_o,
  output logic                     full_o,
  output logic                     empty_o,
  output logic [$clog2(DEPTH):0]   count_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic [AW-1:0]    tail_ptr;
  logic             do_push, do_pop, do_ovr;

  assign full_o   = (count_q == (AW+1)'(DEPTH));
  assign empty_o  = (count_q == '0);
  assign count_o  = count_q;
  assign do_push  = push_i && !full_o;
  assign do_pop   = pop_i && !empty_o;
  assign do_ovr   = ovr_i && !empty_o && !do_push;
  assign tail_ptr = wr_ptr_q - AW'(1);
  assign head_o   = mem_q[rd_ptr_q];
  assign tail_o   = mem_q[tail_ptr];

  // Pointer and occupancy next state; simultaneous push and pop keep the count
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + (AW+1)'(1);
      2'b01:   count_d = count_q - (AW+1)'(1);
      default: count_d = count_q;
    endcase
  end

  // Control state; reset empties the queue and discards pending updates
  always_ff @(posedge clk or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; contents are only meaningful while occupied, so no reset
  always_ff @(posedge clk) begin
    if (do_push)     mem_q[wr_ptr_q] <= wdata_i;
    else if (do_ovr) mem_q[tail_ptr] <= wdata_i;
  end

endmodule

// File: rtl/btb_update_unit.sv
// BTB update unit: classifies each resolved branch against its fetch-time
// BTB prediction, pulses flush with the corrected fetch address on a
// mispredict, counts mispredicts, and queues INSERT/INVALIDATE writes to the
// BTB through a small FIFO with a valid/ready port.
// Optional build macro: BTB_UPD_COALESCE_EN -- an update to the same pc as
// the newest queued entry rewrites that entry instead of taking a new slot.
module btb_update_unit
  import btb_pkg::*;
#(
  parameter int W_PC       = W_PC_DEFAULT,
  parameter int W_BTA      = W_BTA_DEFAULT,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             ex_valid,
  input  logic [W_PC-1:0]  ex_pc,
  input  logic [W_BTA-1:0] ex_pc_plus4,
  input  logic             ex_taken,
  input  logic [W_BTA-1:0] ex_target,
  input  logic             ex_pred_hit,
  input  logic [W_BTA-1:0] ex_pred_bta,
  output logic             flush,
  output logic [W_BTA-1:0] redirect_pc,
  output logic             stall,
  output logic             upd_valid,
  input  logic             upd_ready,
  output logic [1:0]       upd_kind,
  output logic [W_PC-1:0]  upd_pc,
  output logic [W_BTA-1:0] upd_bta,
  output logic [15:0]      mispred_cnt
);

  localparam int W_ENT = upd_entry_w(W_PC, W_BTA);
  localparam int W_CNT = $clog2(FIFO_DEPTH) + 1;

  cls_e             cls;
  logic             mispred;
  logic [W_BTA-1:0] redir_target;
  logic [1:0]       ent_kind;
  logic [W_BTA-1:0] ent_bta;

  logic             flush_q, flush_d;
  logic [W_BTA-1:0] redirect_q, redirect_d;
  logic [15:0]      cnt_q, cnt_d;

  logic [W_ENT-1:0] enq_entry, head_entry, tail_entry;
  logic             fifo_full, fifo_empty;
  logic [W_CNT-1:0] fifo_count;
  logic             enq, push, pop, overwrite;
  logic             unused_fifo;

  // Compare the actual outcome with what fetch predicted
  always_comb begin
    cls = CLS_CORRECT;
    if (ex_valid) begin
      if (ex_taken) begin
        if (!ex_pred_hit || (ex_pred_bta != ex_target)) cls = CLS_INSERT;
      end else if (ex_pred_hit) begin
        cls = CLS_INVALIDATE;
      end
    end
  end

  assign mispred      = (cls != CLS_CORRECT);
  assign redir_target = (cls == CLS_INVALIDATE) ? ex_pc_plus4 : ex_target;
  assign ent_kind     = (cls == CLS_INVALIDATE) ? UPD_INVALIDATE : UPD_INSERT;
  assign ent_bta      = (cls == CLS_INVALIDATE) ? '0 : ex_target;

  // Flush pulse, held redirect address and saturating mispredict count
  always_comb begin
    flush_d    = mispred;
    redirect_d = mispred ? redir_target : redirect_q;
    cnt_d      = (mispred && (cnt_q != 16'hFFFF)) ? cnt_q + 16'd1 : cnt_q;
  end

  // Registered mispredict outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      flush_q    <= 1'b0;
      redirect_q <= '0;
      cnt_q      <= '0;
    end else begin
      flush_q    <= flush_d;
      redirect_q <= redirect_d;
      cnt_q      <= cnt_d;
    end
  end

  assign flush       = flush_q;
  assign redirect_pc = redirect_q;
  assign mispred_cnt = cnt_q;

  // A mispredict while the queue is full still flushes but its update is lost
  assign enq       = mispred && !stall;
  assign enq_entry = {ent_kind, ex_pc, ent_bta};
  assign pop       = upd_valid && upd_ready;

`ifdef BTB_UPD_COALESCE_EN
  // Rewrite the newest entry for a repeated pc, unless that entry is the
  // head leaving this cycle -- then the new update needs its own slot
  assign overwrite = enq && !fifo_empty
                     && (tail_entry[W_BTA +: W_PC] == ex_pc)
                     && !((fifo_count == W_CNT'(1)) && pop);
`else
  assign overwrite = 1'b0;
`endif

  assign push        = enq && !overwrite;
  assign unused_fifo = ^{tail_entry, fifo_count};

  btb_upd_fifo #(
    .WIDTH (W_ENT),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_ni  (reset),
    .push_i  (push),
    .pop_i   (pop),
    .ovr_i   (overwrite),
    .wdata_i (enq_entry),
    .head_o  (head_entry),
    .tail_o  (tail_entry),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  // Head entry drives the BTB port; fields read as zero when nothing is queued
  assign stall     = fifo_full;
  assign upd_valid = !fifo_empty;
  assign upd_kind  = fifo_empty ? 2'b00 : head_entry[W_ENT-1 -: 2];
  assign upd_pc    = fifo_empty ? '0 : head_entry[W_BTA +: W_PC];
  assign upd_bta   = fifo_empty ? '0 : head_entry[W_BTA-1:0];

endmodule

// File: tb/tb_btb_update_unit.sv
// Self-checking bench for btb_update_unit: directed scenarios plus random
// traffic, checked against a queue-based reference model by a monitor.
module tb_btb_update_unit;

  localparam int W_PC  = 8;
  localparam int W_BTA = 32;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             ex_valid;
  logic [W_PC-1:0]  ex_pc;
  logic [W_BTA-1:0] ex_pc_plus4;
  logic             ex_taken;
  logic [W_BTA-1:0] ex_target;
  logic             ex_pred_hit;
  logic [W_BTA-1:0] ex_pred_bta;
  logic             flush;
  logic [W_BTA-1:0] redirect_pc;
  logic             stall;
  logic             upd_valid;
  logic             upd_ready;
  logic [1:0]       upd_kind;
  logic [W_PC-1:0]  upd_pc;
  logic [W_BTA-1:0] upd_bta;
  logic [15:0]      mispred_cnt;

  always #5 clk = ~clk;

  btb_update_unit #(.W_PC(W_PC), .W_BTA(W_BTA), .FIFO_DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .ex_valid    (ex_valid),
    .ex_pc       (ex_pc),
    .ex_pc_plus4 (ex_pc_plus4),
    .ex_taken    (ex_taken),
    .ex_target   (ex_target),
    .ex_pred_hit (ex_pred_hit),
    .ex_pred_bta (ex_pred_bta),
    .flush       (flush),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .upd_valid   (upd_valid),
    .upd_ready   (upd_ready),
    .upd_kind    (upd_kind),
    .upd_pc      (upd_pc),
    .upd_bta     (upd_bta),
    .mispred_cnt (mispred_cnt)
  );

  typedef struct {
    logic [1:0]       kind;
    logic [W_PC-1:0]  pc;
    logic [W_BTA-1:0] bta;
  } ent_t;

  typedef struct {
    int               due;
    bit               fl;
    logic [W_BTA-1:0] rd;
    int               cnt;
  } fexp_t;

  ent_t  mq[$];   // updates the DUT should be holding, oldest first
  fexp_t fq[$];   // expected flush/redirect/count, tagged with the cycle due
  int    m_cnt  = 0;
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;
  bit    coalesce;

  initial begin
`ifdef BTB_UPD_COALESCE_EN
    coalesce = 1'b1;
`else
    coalesce = 1'b0;
`endif
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: at mid-cycle, check transfers about to happen and due flush results
  initial begin
    ent_t  e;
    fexp_t f;
    forever begin
      @(negedge clk);
      if (reset === 1'b1) begin
        if (upd_valid && upd_ready) begin
          if (mq.size() == 0) begin
            check("upd_unexpected", upd_valid, 0);
          end else begin
            e = mq.pop_front();
            check("xfer_kind", upd_kind, e.kind);
            check("xfer_pc", upd_pc, e.pc);
            check("xfer_bta", upd_bta, e.bta);
          end
        end
        if (fq.size() > 0 && fq[0].due == cyc) begin
          f = fq.pop_front();
          check("flush", flush, f.fl);
          if (f.fl) check("redirect_pc", redirect_pc, f.rd);
          check("mispred_cnt", mispred_cnt, f.cnt);
        end
      end
    end
  end

  // One execute cycle: check registered state, drive inputs, advance the model
  task automatic step(input bit v, input logic [W_PC-1:0] pc, input logic [W_BTA-1:0] p4,
                      input bit tk, input logic [W_BTA-1:0] tgt, input bit hit,
                      input logic [W_BTA-1:0] pb, input bit rdy);
    bit    mis, inv, popping;
    int    sz;
    ent_t  e;
    fexp_t f;
    sz = mq.size();
    check("stall", stall, sz == DEPTH);
    check("upd_valid", upd_valid, sz > 0);
    if (sz > 0) begin
      check("head_kind", upd_kind, mq[0].kind);
      check("head_pc", upd_pc, mq[0].pc);
      check("head_bta", upd_bta, mq[0].bta);
    end
    ex_valid = v; ex_pc = pc; ex_pc_plus4 = p4; ex_taken = tk;
    ex_target = tgt; ex_pred_hit = hit; ex_pred_bta = pb; upd_ready = rdy;
    // Correct only if the BTB said taken-to-target for a taken branch, or
    // said nothing for a not-taken one
    mis = v && ((tk != hit) || (tk && (pb != tgt)));
    inv = mis && !tk;
    if (mis && m_cnt < 65535) m_cnt++;
    f.due = cyc + 1; f.fl = mis; f.rd = inv ? p4 : tgt; f.cnt = m_cnt;
    fq.push_back(f);
    if (v && sz == DEPTH)
      $display("NOTE protocol violation: ex_valid while stall, update dropped (pc %0h)", pc);
    if (mis && sz < DEPTH) begin
      e.kind = inv ? 2'b10 : 2'b01;
      e.pc   = pc;
      e.bta  = inv ? '0 : tgt;
      popping = rdy && (sz > 0);
      if (coalesce && sz > 0 && mq[sz-1].pc == pc && !(sz == 1 && popping)) mq[sz-1] = e;
      else mq.push_back(e);
    end
    @(posedge clk); #1;
  endtask

  task automatic idle(input int n, input bit rdy);
    for (int i = 0; i < n; i++)
      step(0, W_PC'($urandom), $urandom, $urandom_range(0, 1), $urandom,
           $urandom_range(0, 1), $urandom, rdy);
  endtask

  // Assert reset with random inputs, check outputs clear at once, release
  task automatic do_reset(input int n);
    reset = 1'b0;
    #1;
    check("rst_flush", flush, 0);
    check("rst_redirect", redirect_pc, 0);
    check("rst_upd_valid", upd_valid, 0);
    check("rst_upd_kind", upd_kind, 0);
    check("rst_upd_pc", upd_pc, 0);
    check("rst_upd_bta", upd_bta, 0);
    check("rst_cnt", mispred_cnt, 0);
    check("rst_stall", stall, 0);
    mq.delete(); fq.delete(); m_cnt = 0;
    for (int i = 0; i < n; i++) begin
      ex_valid = 1'b1; ex_pc = W_PC'($urandom); ex_taken = $urandom_range(0, 1);
      ex_target = $urandom; ex_pred_hit = $urandom_range(0, 1);
      ex_pred_bta = $urandom; ex_pc_plus4 = $urandom; upd_ready = $urandom_range(0, 1);
      @(posedge clk); #1;
    end
    check("rst_hold_flush", flush, 0);
    check("rst_hold_valid", upd_valid, 0);
    ex_valid = 1'b0;
    reset = 1'b1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [W_BTA-1:0] r;
    bit v;
    reset = 1'b0; ex_valid = 1'b0; ex_pc = '0; ex_pc_plus4 = '0; ex_taken = 1'b0;
    ex_target = '0; ex_pred_hit = 1'b0; ex_pred_bta = '0; upd_ready = 1'b0;
    @(posedge clk); #1;
    do_reset(3);

    // Taken, no BTB hit: INSERT, held until accepted
    step(1, 8'h08, 32'h0C, 1, 32'h11, 0, 32'h0, 0);
    idle(2, 0);
    idle(3, 1);

    // Not taken but predicted: INVALIDATE to fall-through
    step(1, 8'h12, 32'h16, 0, 32'h40, 1, 32'h40, 1);
    idle(2, 1);
    // Correct taken prediction: nothing happens
    step(1, 8'h20, 32'h24, 1, 32'h22, 1, 32'h22, 1);
    idle(2, 1);
    // Hit with wrong target: INSERT with the new target
    step(1, 8'h30, 32'h34, 1, 32'h90, 1, 32'h80, 1);
    idle(2, 1);

    // Backpressure: fill, overflow one, then drain in order
    do_reset(1);
    step(1, 8'h08, 32'h0C, 1, 32'h11, 0, 32'h0, 0);
    step(1, 8'h12, 32'h16, 1, 32'h33, 0, 32'h0, 0);
    step(1, 8'h16, 32'h1A, 1, 32'h55, 0, 32'h0, 0);
    idle(2, 0);
    check("cnt_after_three", mispred_cnt, 3);
    idle(4, 1);

    // Same-pc back-to-back updates under backpressure
    do_reset(1);
    step(1, 8'h08, 32'h0C, 1, 32'h11, 0, 32'h0, 0);
    step(1, 8'h08, 32'h0C, 1, 32'h44, 0, 32'h0, 0);
    check("coalesce_stall", stall, coalesce ? 0 : 1);
    idle(4, 1);

    // Random traffic; upstream honours stall
    do_reset(1);
    for (int i = 0; i < 3000; i++) begin
      v = ($urandom_range(0, 3) != 0) && (mq.size() < DEPTH);
      r = $urandom_range(0, 255);
      step(v, W_PC'($urandom_range(0, 3)), $urandom_range(0, 255), $urandom_range(0, 1),
           r, $urandom_range(0, 1), ($urandom_range(0, 1) != 0) ? r : $urandom_range(0, 255),
           $urandom_range(0, 2) != 0);
    end
    idle(4, 1);

    // Reset with updates pending drops them immediately
    step(1, 8'h41, 32'h0, 1, 32'h71, 0, 32'h0, 0);
    step(1, 8'h42, 32'h0, 1, 32'h72, 0, 32'h0, 0);
    do_reset(2);
    idle(2, 1);

    // Counter saturation
    for (int i = 0; i < 65540; i++)
      step(1, W_PC'($urandom), $urandom, 1, $urandom, 0, $urandom, 1);
    idle(3, 1);
    check("cnt_saturated", mispred_cnt, 16'hFFFF);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
